// File: rtl/drive_pkg.sv
// Shared encodings for the drive scheduler: FSM states (also the mode LED code),
// servo dir values, motor speed and rotation codes, IR road_flag patterns.
package drive_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_START   = 3'd1,
        ST_FOLLOW  = 3'd2,
        ST_SEARCH  = 3'd3,
        ST_BRAKE   = 3'd4,
        ST_BACK    = 3'd5,
        ST_STOPPED = 3'd6
    } state_t;

    localparam logic [2:0] DIR_L = 3'b000;
    localparam logic [2:0] DIR_S = 3'b011;
    localparam logic [2:0] DIR_R = 3'b110;

    localparam logic [1:0] SPD_STOP = 2'b00;
    localparam logic [1:0] SPD_NORM = 2'b01;
    localparam logic [1:0] SPD_FAST = 2'b10;

    localparam logic [1:0] CH_BRK = 2'b00;
    localparam logic [1:0] CH_FWD = 2'b01;
    localparam logic [1:0] CH_REV = 2'b10;

    // road_flag: [1] left sensor, [0] right sensor, 1 = over black line
    localparam logic [1:0] RF_NONE  = 2'b00;
    localparam logic [1:0] RF_RIGHT = 2'b01;
    localparam logic [1:0] RF_LEFT  = 2'b10;
    localparam logic [1:0] RF_BOTH  = 2'b11;

endpackage

// File: rtl/drive_sched_if.sv
// Bundle of follow-path requests, sensor inputs and drive outputs of drive_sched.
// master = stimulus / upstream side, slave = the scheduler.
interface drive_sched_if;
    logic       switch;
    logic [1:0] road_flag;
    logic [2:0] f_dir;
    logic [1:0] f_speed;
    logic [1:0] f_choose;
    logic       obst_req;
    logic [2:0] dir;
    logic [1:0] speed;
    logic [1:0] choose;
    logic [2:0] mode;
    logic       lost;

    modport master (
        output switch, road_flag, f_dir, f_speed, f_choose, obst_req,
        input  dir, speed, choose, mode, lost
    );

    modport slave (
        input  switch, road_flag, f_dir, f_speed, f_choose, obst_req,
        output dir, speed, choose, mode, lost
    );
endinterface

// File: rtl/dir_rate_limit.sv
// Servo dir register that refuses a new value until HOLD_CYC cycles after the
// previous change; bypass applies the request immediately.
module dir_rate_limit
    import drive_pkg::*;
#(
    parameter int unsigned HOLD_CYC = 5,
    parameter int unsigned CNT_W    = 8
) (
    input  logic       clk_100,
    input  logic       rst,
    input  logic [2:0] req_dir,
    input  logic       bypass,
    output logic [2:0] dir
);

    localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(HOLD_CYC);

    // held = cycles the current dir has been on the output, saturating at HOLD_MAX
    logic [CNT_W-1:0] held;

    always_ff @(posedge clk_100 or posedge rst) begin
        if (rst) begin
            dir  <= DIR_S;
            held <= '0;
        end else if (req_dir != dir && (bypass || held >= HOLD_MAX)) begin
            dir  <= req_dir;
            held <= CNT_W'(1);
        end else if (held < HOLD_MAX) begin
            held <= held + 1'b1;
        end
    end

endmodule

// File: rtl/drive_sched.sv
// Drive mode sequencer/arbiter: start ramp, line follow, lost-line search,
// obstacle retreat and stop line. Define DRIVE_SCHED_BOOST_EN for straight-line boost.
module drive_sched
    import drive_pkg::*;
#(
    parameter int unsigned START_CYC  = 50,
    parameter int unsigned LOST_CYC   = 20,
    parameter int unsigned SEARCH_CYC = 200,
    parameter int unsigned STOP_CYC   = 10,
    parameter int unsigned BACK_CYC   = 100,
    parameter int unsigned HOLD_CYC   = 5,
    parameter int unsigned CNT_W      = 8
) (
    input logic          clk_100,
    input logic          rst,
    drive_sched_if.slave bus
);

    localparam logic [CNT_W-1:0] START_LAST  = CNT_W'(START_CYC - 1);
    localparam logic [CNT_W-1:0] LOST_LAST   = CNT_W'(LOST_CYC - 1);
    localparam logic [CNT_W-1:0] SEARCH_LAST = CNT_W'(SEARCH_CYC - 1);
    localparam logic [CNT_W-1:0] STOP_LAST   = CNT_W'(STOP_CYC - 1);
    localparam logic [CNT_W-1:0] BACK_LAST   = CNT_W'(BACK_CYC - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] phase, phase_nxt;
    logic [CNT_W-1:0] lost_run, lost_run_nxt;
    logic [CNT_W-1:0] stop_run, stop_run_nxt;
    logic             side_left, side_left_nxt;
    logic [2:0]       dir_req;
    logic             dir_bypass;
    logic [1:0]       speed_nxt, choose_nxt;
    logic [1:0]       rf;

    assign rf = bus.road_flag;

`ifdef DRIVE_SCHED_BOOST_EN
    logic [6:0] boost_cnt, boost_nxt;
`endif

    always_comb begin
        state_nxt     = state;
        phase_nxt     = (phase == '1) ? phase : phase + 1'b1;
        lost_run_nxt  = '0;
        stop_run_nxt  = '0;
        side_left_nxt = side_left;

        if (!bus.switch) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    state_nxt = ST_START;
                    phase_nxt = '0;
                end
                ST_START:
                    if (phase == START_LAST) state_nxt = ST_FOLLOW;
                ST_FOLLOW: begin
                    if (rf == RF_RIGHT)     side_left_nxt = 1'b0;
                    else if (rf == RF_LEFT) side_left_nxt = 1'b1;
                    if (rf == RF_NONE)
                        lost_run_nxt = (lost_run == '1) ? lost_run : lost_run + 1'b1;
                    if (rf == RF_BOTH)
                        stop_run_nxt = (stop_run == '1) ? stop_run : stop_run + 1'b1;
                    if (bus.obst_req) begin
                        state_nxt = ST_BRAKE;
                    end else if (rf == RF_BOTH && stop_run == STOP_LAST) begin
                        state_nxt = ST_STOPPED;
                    end else if (rf == RF_NONE && lost_run == LOST_LAST) begin
                        state_nxt = ST_SEARCH;
                        phase_nxt = '0;
                    end
                end
                ST_SEARCH: begin
                    if (bus.obst_req)           state_nxt = ST_BRAKE;
                    else if (rf != RF_NONE)     state_nxt = ST_FOLLOW;
                    else if (phase == SEARCH_LAST) state_nxt = ST_STOPPED;
                end
                ST_BRAKE: begin
                    state_nxt = ST_BACK;
                    phase_nxt = '0;
                end
                ST_BACK: begin
                    if (bus.obst_req)             phase_nxt = '0;
                    else if (phase == BACK_LAST)  state_nxt = ST_FOLLOW;
                end
                ST_STOPPED: ;
                default: state_nxt = ST_IDLE;
            endcase
        end

        // Outputs are decoded from the next state so they register alongside it
        dir_req    = DIR_S;
        dir_bypass = 1'b1;
        speed_nxt  = SPD_STOP;
        choose_nxt = CH_FWD;
        case (state_nxt)
            ST_START: begin
                dir_bypass = 1'b0;
                speed_nxt  = SPD_NORM;
            end
            ST_FOLLOW: begin
                dir_bypass = 1'b0;
                dir_req    = bus.f_dir;
                speed_nxt  = bus.f_speed;
                choose_nxt = bus.f_choose;
            end
            ST_SEARCH: begin
                dir_bypass = 1'b0;
                dir_req    = side_left ? DIR_L : DIR_R;
                speed_nxt  = SPD_NORM;
            end
            ST_BRAKE:   choose_nxt = CH_BRK;
            ST_BACK: begin
                speed_nxt  = SPD_NORM;
                choose_nxt = CH_REV;
            end
            ST_STOPPED: choose_nxt = CH_BRK;
            default: ;
        endcase

`ifdef DRIVE_SCHED_BOOST_EN
        boost_nxt = '0;
        if (state_nxt == ST_FOLLOW && bus.f_dir == DIR_S && bus.f_speed == SPD_NORM)
            boost_nxt = (boost_cnt == 7'd64) ? boost_cnt : boost_cnt + 7'd1;
        if (boost_nxt == 7'd64) speed_nxt = SPD_FAST;
`endif
    end

    always_ff @(posedge clk_100 or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            phase      <= '0;
            lost_run   <= '0;
            stop_run   <= '0;
            side_left  <= 1'b0;
            bus.speed  <= SPD_STOP;
            bus.choose <= CH_FWD;
        end else begin
            state      <= state_nxt;
            phase      <= phase_nxt;
            lost_run   <= lost_run_nxt;
            stop_run   <= stop_run_nxt;
            side_left  <= side_left_nxt;
            bus.speed  <= speed_nxt;
            bus.choose <= choose_nxt;
        end
    end

`ifdef DRIVE_SCHED_BOOST_EN
    always_ff @(posedge clk_100 or posedge rst) begin
        if (rst) boost_cnt <= '0;
        else     boost_cnt <= boost_nxt;
    end
`endif

    assign bus.mode = state;
    assign bus.lost = (state == ST_SEARCH);

    dir_rate_limit #(
        .HOLD_CYC (HOLD_CYC),
        .CNT_W    (CNT_W)
    ) u_dir_rate_limit (
        .clk_100 (clk_100),
        .rst     (rst),
        .req_dir (dir_req),
        .bypass  (dir_bypass),
        .dir     (bus.dir)
    );

endmodule

// File: doc/drive_sched.md
Name: drive_sched

Overview:
- Mode sequencer and arbiter for the car's drive outputs (servo dir, motor speed, motor choose).
- Shares the drive between three sources:
  - the line-follow command path;
  - an obstacle-retreat request;
  - an internal lost-line search routine.
- Adds start-up ramp, stop-line detection and servo rate limiting.
- Sits between the line-follow logic and the servo/motor drivers; all timing counts clk_100 cycles.

Parameters:
- START_CYC, 50, cycles at speed 01 after enable before follow commands are passed.
- LOST_CYC, 20, consecutive road_flag==00 cycles before entering SEARCH.
- SEARCH_CYC, 200, max SEARCH cycles before giving up (STOPPED).
- STOP_CYC, 10, consecutive road_flag==11 cycles that count as the stop line.
- BACK_CYC, 100, reverse duration during obstacle retreat.
- HOLD_CYC, 5, minimum cycles between two dir output changes.
- CNT_W, 8, width of the shared phase counter; parameters must be < 2^CNT_W.

Ports:
- clk_100  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- switch  in  1  run enable; 0 forces IDLE.
- road_flag  in  2  IR pair, [1] left, [0] right, 1 = black line.
- f_dir  in  3  follow-path direction request.
- f_speed  in  2  follow-path speed request.
- f_choose  in  2  follow-path rotation request.
- obst_req  in  1  level; obstacle ahead.
- dir  out  3  servo command: 000 left, 011 straight, 110 right.
- speed  out  2  motor speed: 00 stop, 01 normal, 10 fast.
- choose  out  2  motor rotation: 01 forward, 10 reverse, 00 brake.
- mode  out  3  current state encoding, for LEDs/debug.
- lost  out  1  high while in SEARCH.

Behaviour:
- Reset (async, rst=1):
  - state IDLE; dir=011, speed=00, choose=01, mode=IDLE, lost=0.
  - All counters 0; last_side=right.
- All outputs registered; one cycle latency from input change to output.
- States (mode encoding): IDLE=0, START=1, FOLLOW=2, SEARCH=3, BRAKE=4, BACK=5, STOPPED=6.
- Priority, evaluated every cycle: switch=0 > obst_req > stop line > lost-line > follow.
- switch=0 in any state:
  - next state IDLE; dir=011, speed=00, choose=01.
- IDLE:
  - switch=1 -> START, counter cleared.
- START:
  - dir=011, speed=01, choose=01.
  - Counter reaches START_CYC-1 -> FOLLOW.
  - obst_req ignored in START (car crawls).
- FOLLOW:
  - Outputs track f_dir/f_speed/f_choose, subject to the dir hold rule.
  - road_flag==01 or 10 latches last_side (01 -> right, 10 -> left).
  - road_flag==00 for LOST_CYC consecutive cycles -> SEARCH.
  - road_flag==11 for STOP_CYC consecutive cycles -> STOPPED.
  - Any other flag value resets the respective run counter.
- SEARCH:
  - lost=1; speed=01, choose=01; dir=110 if last_side=right, else 000.
  - road_flag != 00 -> FOLLOW the next cycle.
  - SEARCH_CYC cycles elapsed -> STOPPED.
- obst_req=1 in FOLLOW or SEARCH:
  - -> BRAKE for exactly 1 cycle with speed=00, choose=00.
  - Then -> BACK: dir=011, speed=01, choose=10 for BACK_CYC cycles.
  - Then -> FOLLOW, with run counters cleared.
  - obst_req re-asserting during BACK restarts the BACK count.
- STOPPED:
  - speed=00, choose=00, dir=011.
  - Leaves only via switch=0 (-> IDLE).
- Dir hold rule:
  - A new dir value is applied only if ≥ HOLD_CYC cycles have passed since the last dir change; otherwise the previous dir is kept.
  - The rule is bypassed on entry to IDLE, BRAKE, BACK and STOPPED (immediate 011).
- Run counters saturate; they never wrap.
- Simultaneous 00 and 11 runs cannot occur.
- Reset mid-BACK returns to IDLE with outputs at reset values.

Optional Feature:
- DRIVE_SCHED_BOOST_EN defined:
  - In FOLLOW, if f_dir==011 and f_speed==01 for 64 consecutive cycles, speed is driven 10.
  - Any non-straight f_dir, or leaving FOLLOW, drops speed to f_speed in the same cycle and clears the boost counter.
- Undefined: speed never exceeds f_speed; no boost counter is synthesized.

Decomposition:
- Package drive_pkg holds:
  - state encoding constants;
  - dir constants DIR_L=000, DIR_S=011, DIR_R=110;
  - speed constants SPD_STOP/SPD_NORM/SPD_FAST;
  - choose constants CH_FWD/CH_REV/CH_BRK.
- One sub-module, dir_rate_limit: takes requested dir, bypass and HOLD_CYC, and outputs rate-limited dir.

Test Plan (START_CYC=4, LOST_CYC=3, SEARCH_CYC=8, STOP_CYC=2, BACK_CYC=5, HOLD_CYC=2):
- Reset then switch=1, f_dir=110, f_speed=01: mode 1 for 4 cycles with dir=011; mode 2 afterward, dir=110.
- FOLLOW with road_flag=10 then 00 for 3 cycles: mode=3, lost=1, dir=000. road_flag=01: mode=2 next cycle.
- SEARCH with road_flag held 00 for 8 cycles: mode=6, speed=00, choose=00. switch=0: mode=0.
- FOLLOW, obst_req pulse: one cycle speed=00/choose=00; 5 cycles choose=10, speed=01; then mode=2.
- f_dir toggles 000/110 every cycle in FOLLOW: dir output changes at most every 2 cycles.
- road_flag=11 for 1 cycle then 01: no stop. road_flag=11 for 2 cycles: mode=6.
